gcd_request_queue: RTL and testbench
====================================

Name: gcd_request_queue

Overview:
- Upstream feeder for the GCD engine. Buffers operand pairs from a producer in a small FIFO and presents them on a say-style request interface wired to the engine's request$say port.
- Tracks requests issued but not yet answered, and stalls issue once MAX_OUTSTANDING is reached.
- Completions are reported on rsp$done__ENA, which the top level drives with indication$gcd__ENA & indication$gcd__RDY.

Parameters:
- WIDTH, 32, operand width in bits.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
- MAX_OUTSTANDING, 1, maximum issued-but-unanswered requests; range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- in$say__ENA  input  1  producer enqueue strobe.
- in$say$va  input  WIDTH  operand a.
- in$say$vb  input  WIDTH  operand b.
- in$say__RDY  output  1  FIFO not full.
- out$say__ENA  output  1  head entry valid and credit available.
- out$say$va  output  WIDTH  head operand a.
- out$say$vb  output  WIDTH  head operand b.
- out$say__RDY  input  1  engine accepts.
- rsp$done__ENA  input  1  one completion this cycle.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- outstanding  output  4  issued-not-answered count.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync release): rd/wr pointers, count, outstanding and err are all 0. in$say__RDY=1 and out$say__ENA=0 immediately on RST assertion. FIFO storage is not reset.
- Enqueue fire = in$say__ENA & in$say__RDY. Data is written at wr_ptr; wr_ptr increments modulo DEPTH.
- in$say__RDY = (count != DEPTH). There is no pass-through when full, so a simultaneous dequeue does not free a slot in the same cycle.
- in$say__ENA while full is dropped and sets err.
- out$say$va/vb = storage[rd_ptr], read combinationally from registered storage.
- out$say__ENA = (count != 0) & (outstanding < MAX_OUTSTANDING). ENA is never asserted when empty.
- Issue fire = out$say__ENA & out$say__RDY. rd_ptr increments modulo DEPTH and outstanding increments.
- There is no empty bypass. Enqueue-to-ENA latency is 1 cycle (data written at edge N, ENA high in cycle N+1).
- Simultaneous enqueue and issue: count unchanged, both pointers advance. Legal whenever not full and not empty.
- rsp$done__ENA decrements outstanding.
  - Simultaneous issue and done: outstanding unchanged.
  - done while outstanding==0 (with no issue that cycle): outstanding stays 0, err set.
- With MAX_OUTSTANDING=1 the next issue waits for the done. The earliest re-issue is the cycle after done.
- count = number of enqueue fires minus number of issue fires. It never exceeds DEPTH and never goes below 0.
- err is sticky until RST.
- Pointers wrap modulo DEPTH using natural binary overflow. Full/empty are decided from count, not from pointer compare.

Optional Feature:
- Macro: GCD_REQ_NORMALIZE_EN.
- Defined: on enqueue, if in$say$va < in$say$vb the pair is stored swapped, so the head always satisfies va >= vb. This saves the engine's flip cycle. Comparison is unsigned, WIDTH bits; equal operands are not swapped.
- Undefined: pairs are stored and issued exactly as received.

Test Plan:
- Reset then single enqueue (va=48, vb=18), out$say__RDY=1 → ENA high 1 cycle after enqueue, va=48/vb=18 issued, outstanding=1. ENA stays low until rsp$done__ENA pulses, then count=0.
- Fill 4 entries with out$say__RDY=0 → in$say__RDY=0, count=4. A 5th in$say__ENA sets err=1 and count stays 4. FIFO order is preserved on drain (values 1..4).
- MAX_OUTSTANDING=2; enqueue 3 pairs; RDY=1; no done → exactly 2 issues, outstanding=2. One done → third issues on the next cycle.
- Steady stream with enqueue, issue and done in the same cycle for 10 cycles → count and outstanding constant. Pointers wrap past DEPTH with data intact (incrementing patterns 0x100+i).
- rsp$done__ENA with outstanding=0 → err=1, outstanding=0. Assert RST mid-stream with count=3 → count, outstanding and err all 0 and ENA low asynchronously.
- With GCD_REQ_NORMALIZE_EN: enqueue (va=7, vb=21) → issued va=21, vb=7. Enqueue (9,9) → issued unchanged. Without the macro: (7,21) is issued as-is.

Source files
------------

// File: rtl/gcd_request_queue.sv
// Request FIFO and credit tracker that feeds operand pairs to the GCD engine.
// Optional GCD_REQ_NORMALIZE_EN stores each pair so that va >= vb.
module gcd_request_queue #(
  parameter int WIDTH           = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_say__ENA,
  input  logic [WIDTH-1:0]         in_say_va,
  input  logic [WIDTH-1:0]         in_say_vb,
  output logic                     in_say__RDY,
  output logic                     out_say__ENA,
  output logic [WIDTH-1:0]         out_say_va,
  output logic [WIDTH-1:0]         out_say_vb,
  input  logic                     out_say__RDY,
  input  logic                     rsp_done__ENA,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               outstanding,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0]    MAXO = 4'(MAX_OUTSTANDING);

  logic [WIDTH-1:0] r_va [DEPTH];
  logic [WIDTH-1:0] r_vb [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_out;
  logic             r_err;

  logic             w_full;
  logic             w_empty;
  logic             w_credit;
  logic             w_enq;
  logic             w_iss;
  logic             w_ovf;
  logic             w_spur;
  logic             w_swap;
  logic [WIDTH-1:0] w_wa;
  logic [WIDTH-1:0] w_wb;

  assign w_full   = (r_count == FULL);
  assign w_empty  = (r_count == '0);
  assign w_credit = (r_out < MAXO);

  assign in_say__RDY  = !w_full;
  assign out_say__ENA = !w_empty && w_credit;
  assign out_say_va   = r_va[r_rd];
  assign out_say_vb   = r_vb[r_rd];
  assign count        = r_count;
  assign outstanding  = r_out;
  assign err          = r_err;

  assign w_enq  = in_say__ENA && in_say__RDY;
  assign w_iss  = out_say__ENA && out_say__RDY;
  assign w_ovf  = in_say__ENA && w_full;
  assign w_spur = rsp_done__ENA && !w_iss && (r_out == '0);

`ifdef GCD_REQ_NORMALIZE_EN
  assign w_swap = (in_say_va < in_say_vb);
`else
  assign w_swap = 1'b0;
`endif

  assign w_wa = w_swap ? in_say_vb : in_say_va;
  assign w_wb = w_swap ? in_say_va : in_say_vb;

  // Operand storage, written on enqueue fire only; never reset.
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_va[r_wr] <= w_wa;
      r_vb[r_wr] <= w_wb;
    end
  end

  // FIFO pointers and occupancy; full/empty come from the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wr <= r_wr + AW'(1);
      if (w_iss) r_rd <= r_rd + AW'(1);
      unique case ({w_enq, w_iss})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issued-but-unanswered credit counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out <= '0;
    end else begin
      unique case ({w_iss, rsp_done__ENA})
        2'b10:   r_out <= r_out + 4'd1;
        2'b01:   if (r_out != '0) r_out <= r_out - 4'd1;
        default: r_out <= r_out;
      endcase
    end
  end

  // Sticky error: enqueue into a full FIFO or a done with nothing pending.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_ovf || w_spur) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gcd_request_queue.sv
// Bench for gcd_request_queue: two instances (MAX_OUTSTANDING 1 and 2)
// checked against a queue-based reference model.
module tb_gcd_request_queue;

  localparam int W = 32;
  localparam int D = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  logic         ena   [2];
  logic         rdy_o [2];
  logic         oena  [2];
  logic         ordy  [2];
  logic         done  [2];
  logic         err   [2];
  logic [W-1:0] va    [2];
  logic [W-1:0] vb    [2];
  logic [W-1:0] ova   [2];
  logic [W-1:0] ovb   [2];
  logic [2:0]   cnt   [2];
  logic [3:0]   outs  [2];

  logic [63:0]  mq   [2][$];
  int           mout [2];
  bit           merr [2];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gcd_request_queue #(
      .WIDTH(W),
      .DEPTH(D),
      .MAX_OUTSTANDING(g + 1)
    ) u_dut (
      .CLK          (CLK),
      .RST          (RST),
      .in_say__ENA  (ena[g]),
      .in_say_va    (va[g]),
      .in_say_vb    (vb[g]),
      .in_say__RDY  (rdy_o[g]),
      .out_say__ENA (oena[g]),
      .out_say_va   (ova[g]),
      .out_say_vb   (ovb[g]),
      .out_say__RDY (ordy[g]),
      .rsp_done__ENA(done[g]),
      .count        (cnt[g]),
      .outstanding  (outs[g]),
      .err          (err[g])
    );
  end

  function automatic logic [63:0] norm(logic [31:0] a, logic [31:0] b);
`ifdef GCD_REQ_NORMALIZE_EN
    if (a < b) return {b, a};
`endif
    return {a, b};
  endfunction

  function automatic logic [73:0] snap_dut(int k);
    logic [63:0] d;
    d = oena[k] ? {ova[k], ovb[k]} : 64'd0;
    return {rdy_o[k], oena[k], d, cnt[k], outs[k], err[k]};
  endfunction

  function automatic logic [73:0] snap_ref(int k);
    logic        e;
    logic [63:0] d;
    int          n;
    n = mq[k].size();
    e = (n > 0) && (mout[k] < k + 1);
    d = 64'd0;
    if (e) d = mq[k][0];
    return {1'(n < D), e, d, 3'(n), 4'(mout[k]), merr[k]};
  endfunction

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      ena[k]  = 1'b0;
      ordy[k] = 1'b0;
      done[k] = 1'b0;
      va[k]   = '0;
      vb[k]   = '0;
    end
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mout[k] = 0;
      merr[k] = 1'b0;
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic tick();
    bit          en [2];
    bit          is [2];
    bit          ov [2];
    bit          dn [2];
    logic [63:0] pa [2];
    for (int k = 0; k < 2; k++) begin
      int n;
      n     = mq[k].size();
      en[k] = ena[k] && (n < D);
      is[k] = (n > 0) && (mout[k] < k + 1) && ordy[k];
      ov[k] = ena[k] && (n == D);
      dn[k] = done[k];
      pa[k] = norm(va[k], vb[k]);
    end
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      if (is[k]) void'(mq[k].pop_front());
      if (en[k]) mq[k].push_back(pa[k]);
      if (ov[k]) merr[k] = 1'b1;
      if (dn[k]) begin
        if (!is[k]) begin
          if (mout[k] > 0) mout[k]--;
          else merr[k] = 1'b1;
        end
      end else if (is[k]) begin
        mout[k]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (snap_dut(k) !== snap_ref(k)) begin
        errors++;
        $display("FAIL reset k=%0d got=%h exp=%h", k, snap_dut(k), snap_ref(k));
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    ena[0] = 1'b1; va[0] = 32'd48; vb[0] = 32'd18; ordy[0] = 1'b1;
    tick();
    ena[0] = 1'b0;
    checks++;
    if ({oena[0], ova[0], ovb[0]} !== {1'b1, 32'd48, 32'd18}) begin
      errors++;
      $display("FAIL single_data got=%b/%0d/%0d exp=1/48/18", oena[0], ova[0], ovb[0]);
    end
    tick();
    checks++;
    if (outs[0] !== 4'd1) begin
      errors++;
      $display("FAIL single_out got=%0d exp=1", outs[0]);
    end
    repeat (3) begin
      checks++;
      if (snap_dut(0) !== snap_ref(0)) begin
        errors++;
        $display("FAIL single_wait got=%h exp=%h", snap_dut(0), snap_ref(0));
      end
      tick();
    end
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    checks++;
    if ({outs[0], cnt[0], oena[0]} !== {4'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_done got=%0d/%0d/%b exp=0/0/0", outs[0], cnt[0], oena[0]);
    end
  endtask

  task automatic test_fill();
    logic [31:0] got [$];
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      ena[0] = 1'b1; va[0] = 32'(i); vb[0] = '0;
      tick();
    end
    ena[0] = 1'b0;
    checks++;
    if ({rdy_o[0], cnt[0]} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL fill_full got=%b/%0d exp=0/4", rdy_o[0], cnt[0]);
    end
    ena[0] = 1'b1; va[0] = 32'd5;
    tick();
    ena[0] = 1'b0;
    checks++;
    if ({err[0], cnt[0]} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL fill_ovf got=%b/%0d exp=1/4", err[0], cnt[0]);
    end
    ordy[0] = 1'b1;
    for (int c = 0; c < 40 && (mq[0].size() > 0 || mout[0] > 0); c++) begin
      done[0] = (mout[0] > 0);
      if (oena[0] && ordy[0]) got.push_back(ova[0]);
      checks++;
      if (snap_dut(0) !== snap_ref(0)) begin
        errors++;
        $display("FAIL fill_drain got=%h exp=%h", snap_dut(0), snap_ref(0));
      end
      tick();
    end
    idle();
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL drain_len got=%0d exp=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 32'(i + 1)) begin
          errors++;
          $display("FAIL drain_order i=%0d got=%0d exp=%0d", i, got[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_max2();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ena[1] = 1'b1; va[1] = 32'(100 + i); vb[1] = 32'(i);
      tick();
    end
    ena[1] = 1'b0;
    ordy[1] = 1'b1;
    repeat (5) begin
      checks++;
      if (snap_dut(1) !== snap_ref(1)) begin
        errors++;
        $display("FAIL max2_issue got=%h exp=%h", snap_dut(1), snap_ref(1));
      end
      tick();
    end
    checks++;
    if ({outs[1], cnt[1], oena[1]} !== {4'd2, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL max2_stall got=%0d/%0d/%b exp=2/1/0", outs[1], cnt[1], oena[1]);
    end
    done[1] = 1'b1;
    tick();
    done[1] = 1'b0;
    checks++;
    if ({oena[1], ova[1]} !== {1'b1, 32'd102}) begin
      errors++;
      $display("FAIL max2_reissue got=%b/%0d exp=1/102", oena[1], ova[1]);
    end
    tick();
    checks++;
    if ({outs[1], cnt[1]} !== {4'd2, 3'd0}) begin
      errors++;
      $display("FAIL max2_final got=%0d/%0d exp=2/0", outs[1], cnt[1]);
    end
  endtask

  task automatic test_stream();
    logic [31:0] got [$];
    do_reset();
    ena[1] = 1'b1; va[1] = 32'h100; vb[1] = '0;
    tick();
    va[1] = 32'h101;
    tick();
    ordy[1] = 1'b1; va[1] = 32'h102;
    if (oena[1]) got.push_back(ova[1]);
    tick();
    done[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      va[1] = 32'h103 + 32'(i);
      vb[1] = 32'($urandom_range(0, 255));
      checks++;
      if ({cnt[1], outs[1]} !== {3'd2, 4'd1} || snap_dut(1) !== snap_ref(1)) begin
        errors++;
        $display("FAIL stream i=%0d got=%h exp=%h", i, snap_dut(1), snap_ref(1));
      end
      if (oena[1] && ordy[1]) got.push_back(ova[1]);
      tick();
    end
    idle();
    checks++;
    if (got.size() != 11) begin
      errors++;
      $display("FAIL stream_len got=%0d exp=11", got.size());
    end else begin
      for (int j = 0; j < 11; j++) begin
        checks++;
        if (got[j] !== 32'h100 + 32'(j)) begin
          errors++;
          $display("FAIL stream_data j=%0d got=%h exp=%h", j, got[j], 32'h100 + 32'(j));
        end
      end
    end
  endtask

  task automatic test_bad_done();
    do_reset();
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    checks++;
    if ({err[0], outs[0]} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL spurious_done got=%b/%0d exp=1/0", err[0], outs[0]);
    end
    for (int i = 0; i < 3; i++) begin
      ena[0] = 1'b1; va[0] = 32'(50 + i); vb[0] = '0;
      tick();
    end
    ena[0] = 1'b0;
    checks++;
    if ({cnt[0], oena[0]} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL pre_rst got=%0d/%b exp=3/1", cnt[0], oena[0]);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({cnt[0], outs[0], err[0], oena[0], rdy_o[0]} !== {3'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_rst got=%0d/%0d/%b/%b/%b exp=0/0/0/0/1",
               cnt[0], outs[0], err[0], oena[0], rdy_o[0]);
    end
    do_reset();
  endtask

  task automatic test_normalize();
    logic [63:0] exp_p;
`ifdef GCD_REQ_NORMALIZE_EN
    exp_p = {32'd21, 32'd7};
`else
    exp_p = {32'd7, 32'd21};
`endif
    do_reset();
    ordy[0] = 1'b1;
    ena[0] = 1'b1; va[0] = 32'd7; vb[0] = 32'd21;
    tick();
    ena[0] = 1'b0;
    checks++;
    if ({oena[0], ova[0], ovb[0]} !== {1'b1, exp_p}) begin
      errors++;
      $display("FAIL norm_swap got=%0d/%0d exp=%0d/%0d", ova[0], ovb[0], exp_p[63:32], exp_p[31:0]);
    end
    tick();
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    ena[0] = 1'b1; va[0] = 32'd9; vb[0] = 32'd9;
    tick();
    ena[0] = 1'b0;
    checks++;
    if ({oena[0], ova[0], ovb[0]} !== {1'b1, 32'd9, 32'd9}) begin
      errors++;
      $display("FAIL norm_equal got=%0d/%0d exp=9/9", ova[0], ovb[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        ena[k]  = ($urandom_range(0, 99) < 60);
        va[k]   = $urandom;
        vb[k]   = $urandom;
        ordy[k] = 1'($urandom_range(0, 1));
        done[k] = (mout[k] > 0) && ($urandom_range(0, 2) != 0);
        checks++;
        if (snap_dut(k) !== snap_ref(k)) begin
          errors++;
          $display("FAIL random c=%0d k=%0d got=%h exp=%h", c, k, snap_dut(k), snap_ref(k));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_fill();
    test_max2();
    test_stream();
    test_bad_done();
    test_normalize();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
